sram_ctrl: RTL

Single-port initiator that fronts the 32-bit OpenRAM-style SRAM macro for the core's data/instruction memory path. It accepts valid/ready word requests from the core, drives the SRAM RW port (active-low chip select and write enable, byte write mask), captures read data after the macro's negedge read and returns a valid/ready response. It owns all SRAM port sequencing so the core never sees the macro's mixed-edge timing.

---
 rtl/sram_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready front end for a single-port OpenRAM-style SRAM.
//
// Takes one word request at a time from the core, runs the macro's RW port
// for exactly one cycle, waits one cycle for the macro's negedge read, then
// presents a registered response. Requests whose byte address lies outside
// the macro's range never touch the SRAM. Instead they return rsp_err.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            request handshake
//   req_we/req_addr/req_be/wdata   request payload (sampled only at handshake)
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_err              response payload (rdata is 0 for writes/errors)
//   csb0/web0/wmask0/addr0/din0    SRAM RW port outputs
//   dout0                          SRAM read data
module sram_ctrl #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [NUM_WMASKS-1:0] req_be,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic                  alive_q, alive_d;
  logic                  we_q, we_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic hs;
  logic out_of_range;

  // The low address bits select a byte within the word and have no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  // alive_q holds req_ready low while reset is asserted. It is released one
  // edge after rst_n deasserts.
  assign req_ready    = alive_q & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready));
  assign hs           = req_valid & req_ready;
  assign out_of_range = |req_addr[31:ADDR_WIDTH+2];

  always_comb begin
    state_d     = state_q;
    alive_d     = 1'b1;
    we_d        = we_q;
    csb_d       = 1'b1;
    web_d       = 1'b1;
    wmask_d     = '0;
    addr_d      = addr_q;
    din_d       = din_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      IDLE:   ;
      ACCESS: state_d = WAIT;
      WAIT: begin
        // The macro read on the negedge inside this cycle, so dout0 is settled now.
        rdata_d     = we_q ? '0 : dout0;
        err_d       = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rdata_d     = '0;
          err_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A handshake can only happen in IDLE or in an accepted RESP. In both
    // cases it overrides whatever the case statement chose above.
    if (hs) begin
      if (out_of_range) begin
        rsp_valid_d = 1'b1;
        rdata_d     = '0;
        err_d       = 1'b1;
        state_d     = RESP;
      end else begin
        we_d    = req_we;
        csb_d   = 1'b0;
        web_d   = ~req_we;
        wmask_d = req_we ? req_be : '0;
        addr_d  = req_addr[ADDR_WIDTH+1:2];
        din_d   = req_wdata;
        state_d = ACCESS;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alive_q     <= 1'b0;
      we_q        <= 1'b0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      wmask_q     <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      alive_q     <= alive_d;
      we_q        <= we_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      wmask_q     <= wmask_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign csb0      = csb_q;
  assign web0      = web_q;
  assign wmask0    = wmask_q;
  assign addr0     = addr_q;
  assign din0      = din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
